// File: rtl/req_pending_latch_4.sv
// rtl/req_pending_latch_4.sv - synchronise four request lines, latch rising edges as pending bits until acked
// Tracks overrun per line and blocks new edges on a line for HOLDOFF_CYC cycles after its ack.
module req_pending_latch_4 #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF_CYC = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_req,
   input  logic       i_ack,
   input  logic [1:0] i_ack_idx,
   input  logic       i_ovr_clr,
   output logic [3:0] o_pending,
   output logic       o_any,
   output logic [3:0] o_overrun
);

   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_d [SYNC_STAGES];
   logic [3:0] prev_q, prev_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] overrun_q, overrun_d;
   logic       any_q, any_d;
   logic [3:0] hcnt_q [4];
   logic [3:0] hcnt_d [4];

   logic [3:0] rise_w;
   logic [3:0] clr_w;
   logic [3:0] take_w;

   always_comb begin
      sync_d[0] = i_req;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      prev_d    = sync_q[SYNC_STAGES-1];
      rise_w    = sync_q[SYNC_STAGES-1] & ~prev_q;
      pending_d = pending_q;
      overrun_d = i_ovr_clr ? 4'b0000 : overrun_q;
      any_d     = |pending_q;
      clr_w     = 4'b0000;
      take_w    = 4'b0000;
      for (int n = 0; n < 4; n++) begin
         hcnt_d[n] = (hcnt_q[n] != 4'd0) ? hcnt_q[n] - 4'd1 : 4'd0;
         clr_w[n]  = i_ack && (i_ack_idx == 2'(n)) && pending_q[n];
         take_w[n] = rise_w[n] && (hcnt_q[n] == 4'd0);
         // An accepted edge beats a same-cycle ack: the new event must not be lost.
         if (take_w[n]) begin
            pending_d[n] = 1'b1;
            if (pending_q[n] && !clr_w[n]) begin
               overrun_d[n] = 1'b1;
            end
         end else if (clr_w[n]) begin
            pending_d[n] = 1'b0;
            hcnt_d[n]    = 4'(HOLDOFF_CYC);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= 4'b0000;
         end
         for (int n = 0; n < 4; n++) begin
            hcnt_q[n] <= 4'd0;
         end
         prev_q    <= 4'b0000;
         pending_q <= 4'b0000;
         overrun_q <= 4'b0000;
         any_q     <= 1'b0;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         for (int n = 0; n < 4; n++) begin
            hcnt_q[n] <= hcnt_d[n];
         end
         prev_q    <= prev_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         any_q     <= any_d;
      end
   end

   assign o_pending = pending_q;
   assign o_any     = any_q;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_req_pending_latch_4.sv
// tb/tb_req_pending_latch_4.sv - directed stimulus with a cycle-stamped scoreboard for req_pending_latch_4
module tb_req_pending_latch_4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       ack;
   logic [1:0] ack_idx;
   logic       ovr_clr;
   logic [3:0] pending;
   logic       any;
   logic [3:0] overrun;

   typedef struct {
      int         cyc;
      logic [3:0] pend;
      logic       any;
      logic [3:0] ovr;
      string      nm;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   exp_t drain_e;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   req_pending_latch_4 #(.SYNC_STAGES(2), .HOLDOFF_CYC(4)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_req     (req),
      .i_ack     (ack),
      .i_ack_idx (ack_idx),
      .i_ovr_clr (ovr_clr),
      .o_pending (pending),
      .o_any     (any),
      .o_overrun (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         mon_e = q.pop_front();
         n_tests++;
         if (mon_e.cyc < cyc || pending !== mon_e.pend || any !== mon_e.any || overrun !== mon_e.ovr) begin
            n_fail++;
            $display("FAIL %s (cyc %0d/%0d): got pend=%b any=%b ovr=%b, expected pend=%b any=%b ovr=%b",
                     mon_e.nm, cyc, mon_e.cyc, pending, any, overrun, mon_e.pend, mon_e.any, mon_e.ovr);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_at(input int dc, input logic [3:0] p, input logic a,
                            input logic [3:0] o, input string nm);
      exp_t e;
      e.cyc  = cyc + dc;
      e.pend = p;
      e.any  = a;
      e.ovr  = o;
      e.nm   = nm;
      q.push_back(e);
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; ack = 1'b0; ack_idx = 2'd0; ovr_clr = 1'b0;
      tick(2);
      n_tests++;
      if (pending !== 4'b0000 || any !== 1'b0 || overrun !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_hold_direct: got pend=%b any=%b ovr=%b", pending, any, overrun);
      end
      expect_at(0, 4'b0000, 1'b0, 4'b0000, "reset_state");
      rst = 1'b0;
      tick(3);

      // Latency: raw rise -> pending after 3 cycles, o_any one later
      expect_at(2, 4'b0000, 1'b0, 4'b0000, "lat_before");
      expect_at(3, 4'b0100, 1'b0, 4'b0000, "lat_pending");
      expect_at(4, 4'b0100, 1'b1, 4'b0000, "lat_any");
      req = 4'b0100;
      tick(4);
      ack = 1'b1; ack_idx = 2'd2;
      expect_at(1, 4'b0000, 1'b1, 4'b0000, "ack2_clear");
      expect_at(2, 4'b0000, 1'b0, 4'b0000, "ack2_any");
      tick(1);
      ack = 1'b0; req = 4'b0000;
      tick(8);

      // Ack line 3, edge during hold-off ignored, later edge accepted
      req = 4'b1001;
      tick(3);
      ack = 1'b1; ack_idx = 2'd3; req = 4'b0001;
      expect_at(1, 4'b0001, 1'b1, 4'b0000, "ack3_clear");
      expect_at(5, 4'b0001, 1'b1, 4'b0000, "holdoff_ignore");
      expect_at(6, 4'b1001, 1'b1, 4'b0000, "holdoff_expired");
      tick(1);
      ack = 1'b0; req = 4'b1001;
      tick(1);
      req = 4'b0001;
      tick(1);
      req = 4'b1001;
      tick(3);
      ack = 1'b1; ack_idx = 2'd1;
      expect_at(1, 4'b1001, 1'b1, 4'b0000, "ack_nonpending");
      tick(1);
      ack = 1'b0;

      // Overrun on line 0, then clear
      req = 4'b1000;
      tick(1);
      req = 4'b1001;
      expect_at(3, 4'b1001, 1'b1, 4'b0001, "overrun_set");
      tick(3);
      ovr_clr = 1'b1;
      expect_at(1, 4'b1001, 1'b1, 4'b0000, "overrun_clr");
      tick(1);
      ovr_clr = 1'b0;
      req = 4'b1000;
      tick(1);
      req = 4'b1001;
      tick(2);
      ovr_clr = 1'b1;
      expect_at(1, 4'b1001, 1'b1, 4'b0001, "ovr_clr_set_wins");
      tick(1);
      expect_at(1, 4'b1001, 1'b1, 4'b0000, "ovr_clr_again");
      tick(1);
      ovr_clr = 1'b0;
      ack = 1'b1; ack_idx = 2'd0;
      expect_at(1, 4'b1000, 1'b1, 4'b0000, "ack0");
      expect_at(2, 4'b0000, 1'b1, 4'b0000, "ack3_b");
      expect_at(3, 4'b0000, 1'b0, 4'b0000, "idle_after_acks");
      tick(1);
      ack_idx = 2'd3;
      tick(1);
      ack = 1'b0;
      tick(1);
      req = 4'b0000;
      tick(8);

      // Collision: edge and ack on line 2 in the same cycle
      req = 4'b0100;
      tick(3);
      req = 4'b0000;
      tick(1);
      req = 4'b0100;
      tick(2);
      ack = 1'b1; ack_idx = 2'd2;
      expect_at(1, 4'b0100, 1'b1, 4'b0000, "collision_keep");
      tick(1);
      ack = 1'b0; req = 4'b0000;
      tick(1);
      req = 4'b0100;
      expect_at(3, 4'b0100, 1'b1, 4'b0100, "collision_no_holdoff");
      tick(3);
      ovr_clr = 1'b1; ack = 1'b1; ack_idx = 2'd2;
      expect_at(1, 4'b0000, 1'b1, 4'b0000, "collision_cleanup");
      tick(1);
      ovr_clr = 1'b0; ack = 1'b0; req = 4'b0000;
      tick(8);

      // Stuck-high: one event per line
      req = 4'b1111;
      tick(3);
      expect_at(0, 4'b1111, 1'b0, 4'b0000, "stuck_set");
      expect_at(1, 4'b1110, 1'b1, 4'b0000, "stuck_ack0");
      expect_at(2, 4'b1100, 1'b1, 4'b0000, "stuck_ack1");
      expect_at(3, 4'b1000, 1'b1, 4'b0000, "stuck_ack2");
      expect_at(4, 4'b0000, 1'b1, 4'b0000, "stuck_ack3");
      expect_at(5, 4'b0000, 1'b0, 4'b0000, "stuck_idle");
      for (int i = 0; i < 4; i++) begin
         ack = 1'b1; ack_idx = 2'(i);
         tick(1);
      end
      ack = 1'b0;
      expect_at(43, 4'b0000, 1'b0, 4'b0000, "stuck_final");
      tick(44);
      n_tests++;
      if (pending !== 4'b0000 || overrun !== 4'b0000) begin
         n_fail++;
         $display("FAIL stuck_final_direct: got pend=%b ovr=%b", pending, overrun);
      end

      // Asynchronous reset with pending=1010, then release with lines held high
      req = 4'b0000;
      tick(4);
      req = 4'b1010;
      expect_at(3, 4'b1010, 1'b0, 4'b0000, "pre_reset");
      tick(4);
      expect_at(0, 4'b0000, 1'b0, 4'b0000, "async_reset");
      rst = 1'b1;
      #1;
      n_tests++;
      if (pending !== 4'b0000 || any !== 1'b0 || overrun !== 4'b0000) begin
         n_fail++;
         $display("FAIL async_reset_direct: got pend=%b any=%b ovr=%b", pending, any, overrun);
      end
      tick(2);
      rst = 1'b0;
      expect_at(2, 4'b0000, 1'b0, 4'b0000, "release_quiet");
      expect_at(3, 4'b1010, 1'b0, 4'b0000, "release_edge");
      tick(4);

      for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
      while (q.size() > 0) begin
         drain_e = q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: never sampled, expected at cyc %0d, run ended at cyc %0d", drain_e.nm, drain_e.cyc, cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
